// File: rtl/spike_bin_counter.sv
// Windowed spike counter: two-stage pipelined popcount of the masked spike vector,
// accumulated between step closes and presented as a saturated count with a valid pulse.
module spike_bin_counter #(
  parameter int N_NEURONS = 128,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_NEURONS-1:0] spike_vec,
  input  logic                 spike_valid,
  input  logic                 step,
  output logic [CNT_W-1:0]     spike_cnt,
  output logic                 cnt_valid,
  output logic                 overflow
);

  localparam int GROUPS = N_NEURONS / 16;
  localparam int SUM_W  = $clog2(N_NEURONS + 1);
  // One spare bit above the wider operand so the true sum is never lost before saturation.
  localparam int EXT_W  = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
  localparam logic [EXT_W-1:0] CNT_MAX = {{(EXT_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [N_NEURONS-1:0] masked;
  logic [4:0]           grp_next [GROUPS];
  logic [4:0]           grp_cnt  [GROUPS];
  logic                 s1_step;
  logic [SUM_W-1:0]     sum_next;
  logic [SUM_W-1:0]     s2_sum;
  logic                 s2_step;
  logic [CNT_W-1:0]     acc;
  logic                 ovf_acc;
  logic [EXT_W-1:0]     ext_sum;
  logic                 sat_hit;
  logic [CNT_W-1:0]     sat_val;

  assign masked = spike_vec & {N_NEURONS{spike_valid}};

  // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int g = 0; g < GROUPS; g++) begin
      grp_next[g] = '0;
      for (int b = 0; b < 16; b++) begin
        grp_next[g] = grp_next[g] + {4'b0, masked[g*16 + b]};
      end
    end
  end

  // NOTE: the group-count array is a small bank of pipeline registers, not a RAM, so it is cleared on reset like any other stage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < GROUPS; g++) grp_cnt[g] <= '0;
      s1_step <= 1'b0;
    end else begin
      for (int g = 0; g < GROUPS; g++) grp_cnt[g] <= grp_next[g];
      s1_step <= step;
    end
  end

  always_comb begin
    sum_next = '0;
    for (int g = 0; g < GROUPS; g++) begin
      sum_next = sum_next + SUM_W'(grp_cnt[g]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_sum  <= '0;
      s2_step <= 1'b0;
    end else begin
      s2_sum  <= sum_next;
      s2_step <= s1_step;
    end
  end

  always_comb begin
    ext_sum = EXT_W'(acc) + EXT_W'(s2_sum);
    sat_hit = (ext_sum > CNT_MAX);
    sat_val = sat_hit ? {CNT_W{1'b1}} : ext_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      spike_cnt <= '0;
      overflow  <= 1'b0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      if (s2_step) begin
        // The closing vector belongs to this window; the next window starts empty.
        spike_cnt <= sat_val;
        overflow  <= ovf_acc | sat_hit;
        cnt_valid <= 1'b1;
        acc       <= '0;
        ovf_acc   <= 1'b0;
      end else begin
        acc     <= sat_val;
        ovf_acc <= ovf_acc | sat_hit;
      end
    end
  end

endmodule

// File: tb/tb_spike_bin_counter.sv
// Scoreboard bench for spike_bin_counter: one 32-bit and one 8-bit instance share stimulus;
// a window-level model queues expected closes and a negedge monitor pops and compares.
module tb_spike_bin_counter;

  localparam int N = 128;

  typedef struct {
    longint cnt;
    bit     ovf;
    int     cyc;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [N-1:0] spike_vec;
  logic         spike_valid;
  logic         step;
  logic [31:0]  cnt32;
  logic         valid32;
  logic         ovf32;
  logic [7:0]   cnt8;
  logic         valid8;
  logic         ovf8;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  longint win_sum = 0;
  longint last_cnt [2];
  bit     last_ovf [2];
  exp_t   q0 [$];
  exp_t   q1 [$];

  spike_bin_counter #(.N_NEURONS(N), .CNT_W(32)) dut32 (
    .clk(clk), .reset(reset), .spike_vec(spike_vec), .spike_valid(spike_valid),
    .step(step), .spike_cnt(cnt32), .cnt_valid(valid32), .overflow(ovf32)
  );

  spike_bin_counter #(.N_NEURONS(N), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .spike_vec(spike_vec), .spike_valid(spike_valid),
    .step(step), .spike_cnt(cnt8), .cnt_valid(valid8), .overflow(ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic exp_t make_exp(input longint sum, input longint max, input int t);
    exp_t e;
    e.cnt = (sum > max) ? max : sum;
    e.ovf = (sum > max);
    e.cyc = t + 3;
    return e;
  endfunction

  task automatic flush();
    q0.delete();
    q1.delete();
    win_sum = 0;
    for (int k = 0; k < 2; k++) begin
      last_cnt[k] = 0;
      last_ovf[k] = 1'b0;
    end
  endtask

  // One cycle of stimulus; the model sees the cycle only when reset is released.
  task automatic drive(input logic [N-1:0] v, input logic val, input logic stp, input logic rst);
    @(posedge clk);
    #1;
    reset       = rst;
    spike_vec   = v;
    spike_valid = val;
    step        = stp;
    if (rst) begin
      flush();
    end else begin
      if (val) win_sum += $countones(v);
      if (stp) begin
        q0.push_back(make_exp(win_sum, 64'hFFFF_FFFF, cyc));
        q1.push_back(make_exp(win_sum, 255, cyc));
        win_sum = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    flush();
  endtask

  function automatic logic [N-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [N-1:0] vec_pop(input int k);
    logic [N-1:0] v = '0;
    while ($countones(v) < k) v[$urandom_range(N-1, 0)] = 1'b1;
    return v;
  endfunction

  task automatic mon(input int k, input logic v, input longint cnt, input logic ovf);
    exp_t e;
    bit   due;
    string tag;
    tag = (k == 0) ? "w32" : "w8";
    if (k == 0) due = (q0.size() > 0) && (q0[0].cyc <= cyc);
    else        due = (q1.size() > 0) && (q1[0].cyc <= cyc);
    check({tag, "_cnt_valid"}, longint'(v), longint'(due));
    if (due) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      if (v) begin
        check({tag, "_spike_cnt"}, cnt, e.cnt);
        check({tag, "_overflow"}, longint'(ovf), longint'(e.ovf));
        last_cnt[k] = e.cnt;
        last_ovf[k] = e.ovf;
      end
    end else if (!v) begin
      check({tag, "_hold_cnt"}, cnt, last_cnt[k]);
      check({tag, "_hold_ovf"}, longint'(ovf), longint'(last_ovf[k]));
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid32, longint'(cnt32), ovf32);
    mon(1, valid8, longint'(cnt8), ovf8);
  end

  logic [N-1:0] ones;

  initial begin
    ones        = '1;
    reset       = 1'b1;
    spike_vec   = '0;
    spike_valid = 1'b0;
    step        = 1'b0;
    flush();

    // Reset held with live stimulus, then three quiet cycles with no pulse.
    for (int i = 0; i < 3; i++) drive(rand_vec(), 1'b1, 1'(i % 2), 1'b1);
    idle(3);

    // Basic window: 3 x 128 = 384, 255 saturated on the 8-bit instance.
    drive(ones, 1'b1, 1'b0, 1'b0);
    drive(ones, 1'b1, 1'b0, 1'b0);
    drive(ones, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Valid masking.
    drive(ones, 1'b0, 1'b0, 1'b0);
    drive(vec_pop(5), 1'b1, 1'b1, 1'b0);
    idle(4);

    // Back-to-back closes: 7, 0, 128.
    drive(vec_pop(7), 1'b1, 1'b1, 1'b0);
    drive(ones, 1'b0, 1'b1, 1'b0);
    drive(ones, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Saturation followed by a single-spike window.
    drive(ones, 1'b1, 1'b0, 1'b0);
    drive(ones, 1'b1, 1'b0, 1'b0);
    drive(ones, 1'b1, 1'b1, 1'b0);
    drive(vec_pop(1), 1'b1, 1'b1, 1'b0);
    idle(4);

    // 100 windows closed every second cycle.
    for (int w = 0; w < 100; w++) begin
      drive(rand_vec(), 1'($urandom_range(1, 0)), 1'b0, 1'b0);
      drive(rand_vec(), 1'($urandom_range(1, 0)), 1'b1, 1'b0);
    end
    idle(4);

    // Reset while a close sits in stage 1; that close must vanish.
    for (int i = 0; i < 3; i++) drive(vec_pop(10), 1'b1, 1'b0, 1'b0);
    drive(vec_pop(10), 1'b1, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
    async_reset();
    drive(rand_vec(), 1'b1, 1'b1, 1'b1);
    drive(vec_pop(3), 1'b1, 1'b0, 1'b0);
    drive(vec_pop(3), 1'b1, 1'b1, 1'b0);
    idle(4);

    // Random window lengths including single-cycle windows.
    for (int i = 0; i < 300; i++) begin
      drive(rand_vec(), 1'($urandom_range(3, 0) != 0), 1'($urandom_range(2, 0) == 0), 1'b0);
    end
    idle(4);

    // Close in the first cycle after reset release.
    drive(rand_vec(), 1'b1, 1'b0, 1'b1);
    drive(vec_pop(9), 1'b1, 1'b1, 1'b0);
    idle(6);

    check("drain_w32", longint'(q0.size()), 0);
    check("drain_w8", longint'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
